// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - Multi-channel RGB LED PWM controller with off/static/blink/breathe modes; breathe envelopes exist only with LED_PWM_BREATHE_EN
module led_pwm_ctrl #(
    parameter int  CLK_HZ       = 100_000_000,
    parameter int  TICK_HZ      = 30,
    parameter int  CHANNELS     = 4,
    parameter int  PWM_BITS     = 8,
    parameter int  BREATHE_STEP = 4,
    localparam int CHW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    fpga_sysclk,
    input  logic                    rst_fpga_,
    input  logic                    wr_en,
    input  logic [CHW-1:0]          wr_ch,
    input  logic [1:0]              wr_reg,
    input  logic [PWM_BITS-1:0]     wr_data,
    output logic                    wr_ack,
    output logic                    tick,
    output logic [3*CHANNELS-1:0]   led_rgb
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_RELOAD = PRESC_W'(DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX      = '1;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_STATIC  = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    logic [PRESC_W-1:0]          presc_q, presc_d;
    logic                        tick_now, tick_q, ack_q;
    logic [PWM_BITS-1:0]         pwm_q, pwm_d;
    logic                        period_end;

    // Per channel: duty for {B,G,R} at index [2:0], written via shadow, used from active
    logic [2:0][PWM_BITS-1:0]    sh_duty_q  [CHANNELS];
    logic [2:0][PWM_BITS-1:0]    sh_duty_d  [CHANNELS];
    logic [2:0][PWM_BITS-1:0]    act_duty_q [CHANNELS];
    logic [2:0][PWM_BITS-1:0]    act_duty_d [CHANNELS];
    logic [1:0]                  sh_mode_q  [CHANNELS];
    logic [1:0]                  sh_mode_d  [CHANNELS];
    logic [1:0]                  act_mode_q [CHANNELS];
    logic [1:0]                  act_mode_d [CHANNELS];
    logic [CHANNELS-1:0]         mode_chg;
    logic [CHANNELS-1:0]         phase_q, phase_d;
    logic [3*CHANNELS-1:0]       led_q, led_d;

`ifdef LED_PWM_BREATHE_EN
    localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(BREATHE_STEP);
    logic [PWM_BITS-1:0]         env_q [CHANNELS];
    logic [PWM_BITS-1:0]         env_d [CHANNELS];
    logic [CHANNELS-1:0]         dir_dn_q, dir_dn_d;
`else
    // Keeps the step parameter referenced in builds without envelopes
    localparam int unused_breathe_step = BREATHE_STEP;
`endif

    assign wr_ack  = ack_q;
    assign tick    = tick_q;
    assign led_rgb = led_q;

    // Tick prescaler (down-counter, reload on tick) and free-running PWM counter
    always_comb begin
        tick_now   = (presc_q == '0);
        presc_d    = tick_now ? PRESC_RELOAD : (presc_q - PRESC_W'(1));
        pwm_d      = pwm_q + PWM_BITS'(1);
        period_end = (pwm_q == PWM_MAX);
    end

    // Shadow writes land immediately; active copies shadow as the counter wraps to 0
    always_comb begin
        mode_chg = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sh_duty_d[c]  = sh_duty_q[c];
            sh_mode_d[c]  = sh_mode_q[c];
            act_duty_d[c] = act_duty_q[c];
            act_mode_d[c] = act_mode_q[c];
            if (period_end) begin
                act_duty_d[c] = sh_duty_q[c];
                act_mode_d[c] = sh_mode_q[c];
                mode_chg[c]   = (sh_mode_q[c] != act_mode_q[c]);
            end
            // Out-of-range channel numbers match no channel and are dropped
            if (wr_en && (wr_ch == CHW'(c))) begin
                if (wr_reg == 2'd3) begin
                    sh_mode_d[c] = wr_data[1:0];
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        if (wr_reg == 2'(k)) begin
                            sh_duty_d[c][k] = wr_data;
                        end
                    end
                end
            end
        end
    end

    // Blink phase and breathe envelope: restart on an active mode change, else advance on tick
    always_comb begin
        phase_d = phase_q;
`ifdef LED_PWM_BREATHE_EN
        dir_dn_d = dir_dn_q;
        for (int c = 0; c < CHANNELS; c++) begin
            env_d[c] = env_q[c];
        end
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            if (mode_chg[c]) begin
                phase_d[c] = 1'b1;
`ifdef LED_PWM_BREATHE_EN
                env_d[c]    = '0;
                dir_dn_d[c] = 1'b0;
`endif
            end else if (tick_now) begin
                phase_d[c] = ~phase_q[c];
`ifdef LED_PWM_BREATHE_EN
                // Triangle: saturate at either limit and turn around there
                if (!dir_dn_q[c]) begin
                    if (env_q[c] >= (PWM_MAX - STEP_V)) begin
                        env_d[c]    = PWM_MAX;
                        dir_dn_d[c] = 1'b1;
                    end else begin
                        env_d[c] = env_q[c] + STEP_V;
                    end
                end else begin
                    if (env_q[c] <= STEP_V) begin
                        env_d[c]    = '0;
                        dir_dn_d[c] = 1'b0;
                    end else begin
                        env_d[c] = env_q[c] - STEP_V;
                    end
                end
`endif
            end
        end
    end

    // Pin drive from the current counter and active state; active-low outputs
    always_comb begin
        led_d = '1;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < 3; k++) begin
                case (act_mode_q[c])
                    MODE_OFF:    led_d[3*c+k] = 1'b1;
                    MODE_STATIC: led_d[3*c+k] = ~(pwm_q < act_duty_q[c][k]);
                    MODE_BLINK:  led_d[3*c+k] = ~(phase_q[c] && (pwm_q < act_duty_q[c][k]));
                    MODE_BREATHE: begin
`ifdef LED_PWM_BREATHE_EN
                        led_d[3*c+k] = ~(pwm_q < PWM_BITS'(((2*PWM_BITS)'(act_duty_q[c][k])
                                                           * (2*PWM_BITS)'(env_q[c])) >> PWM_BITS));
`else
                        led_d[3*c+k] = ~(pwm_q < act_duty_q[c][k]);
`endif
                    end
                    default:     led_d[3*c+k] = 1'b1;
                endcase
            end
        end
    end

    // State registers; asynchronous reset drops any write in flight and blanks the LEDs
    always_ff @(posedge fpga_sysclk or negedge rst_fpga_) begin
        if (!rst_fpga_) begin
            presc_q <= PRESC_RELOAD;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            pwm_q   <= '0;
            phase_q <= '1;
            led_q   <= '1;
            for (int c = 0; c < CHANNELS; c++) begin
                sh_duty_q[c]  <= '0;
                act_duty_q[c] <= '0;
                sh_mode_q[c]  <= MODE_OFF;
                act_mode_q[c] <= MODE_OFF;
`ifdef LED_PWM_BREATHE_EN
                env_q[c]      <= '0;
`endif
            end
`ifdef LED_PWM_BREATHE_EN
            dir_dn_q <= '0;
`endif
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_now;
            ack_q   <= wr_en;
            pwm_q   <= pwm_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            for (int c = 0; c < CHANNELS; c++) begin
                sh_duty_q[c]  <= sh_duty_d[c];
                act_duty_q[c] <= act_duty_d[c];
                sh_mode_q[c]  <= sh_mode_d[c];
                act_mode_q[c] <= act_mode_d[c];
`ifdef LED_PWM_BREATHE_EN
                env_q[c]      <= env_d[c];
`endif
            end
`ifdef LED_PWM_BREATHE_EN
            dir_dn_q <= dir_dn_d;
`endif
        end
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb/tb_led_pwm_ctrl.sv - Self-checking bench for led_pwm_ctrl against a cycle-count reference model
`timescale 1ns/1ps
module tb_led_pwm_ctrl;

    localparam int DIV  = 100;
    localparam int NCH  = 4;
    localparam int PB   = 8;
    localparam int PER  = 256;
    localparam int EMAX = 255;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [1:0]  wr_reg;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        tick;
    logic [11:0] led_rgb;

    logic        wr_en3;
    logic [1:0]  wr_ch3;
    logic [1:0]  wr_reg3;
    logic [7:0]  wr_data3;
    logic        wr_ack3;
    logic        tick3;
    logic [8:0]  led_rgb3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    led_pwm_ctrl #(.CLK_HZ(1000), .TICK_HZ(10), .CHANNELS(NCH), .PWM_BITS(PB), .BREATHE_STEP(STEP)) dut (
        .fpga_sysclk(clk), .rst_fpga_(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_reg(wr_reg),
        .wr_data(wr_data), .wr_ack(wr_ack), .tick(tick), .led_rgb(led_rgb));

    led_pwm_ctrl #(.CLK_HZ(1000), .TICK_HZ(10), .CHANNELS(3), .PWM_BITS(PB), .BREATHE_STEP(STEP)) dut3 (
        .fpga_sysclk(clk), .rst_fpga_(rst_n), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_reg(wr_reg3),
        .wr_data(wr_data3), .wr_ack(wr_ack3), .tick(tick3), .led_rgb(led_rgb3));

    // Reference model: everything derived from the number of clock edges since reset release
    int          m_n;
    int          m_sd [NCH][3];
    int          m_ad [NCH][3];
    int          m_sm [NCH];
    int          m_am [NCH];
    bit          m_ph [NCH];
    int          m_env [NCH];
    bit          m_down [NCH];
    logic [11:0] m_led;
    logic        m_tick;
    logic        m_ack;

    task automatic model_reset();
        m_n = 0;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 3; k++) begin
                m_sd[c][k] = 0;
                m_ad[c][k] = 0;
            end
            m_sm[c] = 0; m_am[c] = 0; m_ph[c] = 1'b1; m_env[c] = 0; m_down[c] = 1'b0;
        end
        m_led = 12'hFFF; m_tick = 1'b0; m_ack = 1'b0;
    endtask

    function automatic bit m_lit(input int c, input int k, input int p);
        bit r;
        int d;
        d = m_ad[c][k];
        r = 1'b0;
        case (m_am[c])
            1: r = (p < d);
            2: r = m_ph[c] && (p < d);
            3: begin
`ifdef LED_PWM_BREATHE_EN
                r = (p < ((d * m_env[c]) >> PB));
`else
                r = (p < d);
`endif
            end
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        int p;
        m_n++;
        p = (m_n - 1) % PER;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 3; k++)
                m_led[3*c+k] = !m_lit(c, k, p);
        m_tick = ((m_n % DIV) == 0);
        m_ack  = wr_en;
        for (int c = 0; c < NCH; c++) begin
            if ((m_n % PER) == 0 && m_sm[c] != m_am[c]) begin
                m_ph[c] = 1'b1; m_env[c] = 0; m_down[c] = 1'b0;
            end else if (m_tick) begin
                m_ph[c] = !m_ph[c];
                if (!m_down[c]) begin
                    m_env[c] += STEP;
                    if (m_env[c] >= EMAX) begin m_env[c] = EMAX; m_down[c] = 1'b1; end
                end else begin
                    m_env[c] -= STEP;
                    if (m_env[c] <= 0) begin m_env[c] = 0; m_down[c] = 1'b0; end
                end
            end
            if ((m_n % PER) == 0) begin
                m_am[c] = m_sm[c];
                for (int k = 0; k < 3; k++) m_ad[c][k] = m_sd[c][k];
            end
        end
        if (wr_en) begin
            if (wr_reg == 2'd3) m_sm[wr_ch] = int'(wr_data[1:0]);
            else                m_sd[wr_ch][wr_reg] = int'(wr_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_write(input int ch, input int rg, input int data);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_reg = 2'(rg); wr_data = 8'(data);
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int first_tick;
        first_tick = -1;
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_reg = '0; wr_data = '0;
        wr_en3 = 1'b0; wr_ch3 = '0; wr_reg3 = '0; wr_data3 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (led_rgb !== 12'hFFF) begin n_fail++; $display("FAIL reset_led got=%h exp=fff", led_rgb); end
        n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tick); end
        n_chk++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", wr_ack); end
        n_chk++; if (led_rgb3 !== 9'h1FF) begin n_fail++; $display("FAIL reset_led3 got=%h exp=1ff", led_rgb3); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 350; i++) begin
            step();
            n_chk++; if (tick !== m_tick) begin n_fail++; $display("FAIL reset_tick_seq n=%0d got=%b exp=%b", m_n, tick, m_tick); end
            n_chk++; if (led_rgb !== m_led) begin n_fail++; $display("FAIL reset_led_seq n=%0d got=%h exp=%h", m_n, led_rgb, m_led); end
            if (tick === 1'b1 && first_tick < 0) first_tick = i;
        end
        n_chk++; if (first_tick != 100) begin n_fail++; $display("FAIL first_tick got=%0d exp=100", first_tick); end
    endtask

    task automatic test_static();
        int per, pre, cnt;
        per = 0; pre = 0; cnt = 0;
        do_write(2, 0, 64);
        do_write(2, 3, 1);
        for (int i = 0; i < 1100; i++) begin
            step();
            n_chk++; if (led_rgb !== m_led) begin n_fail++; $display("FAIL static_led n=%0d got=%h exp=%h", m_n, led_rgb, m_led); end
            if (((m_n - 1) % PER) == 0) per++;
            if (per == 0 && led_rgb[6] === 1'b0) pre++;
            if (per == 2 && led_rgb[6] === 1'b0) cnt++;
            if (per == 3) break;
        end
        n_chk++; if (pre != 0) begin n_fail++; $display("FAIL static_midperiod lit_before_start got=%0d exp=0", pre); end
        n_chk++; if (cnt != 64) begin n_fail++; $display("FAIL static_duty64 lit_cycles got=%0d exp=64", cnt); end
    endtask

    task automatic test_blink();
        int zero_w, full_w, lit, guard;
        zero_w = 0; full_w = 0; guard = 0;
        do_write(0, 1, 255);
        do_write(0, 3, 2);
        while ((m_am[0] != 2 || !m_tick) && guard < 600) begin
            step();
            guard++;
            n_chk++; if (led_rgb !== m_led) begin n_fail++; $display("FAIL blink_led n=%0d got=%h exp=%h", m_n, led_rgb, m_led); end
        end
        n_chk++; if (guard >= 600) begin n_fail++; $display("FAIL blink_start timeout got=%0d exp<600", guard); end
        for (int w = 0; w < 10; w++) begin
            lit = 0;
            for (int i = 0; i < DIV; i++) begin
                step();
                n_chk++; if (led_rgb !== m_led) begin n_fail++; $display("FAIL blink_led n=%0d got=%h exp=%h", m_n, led_rgb, m_led); end
                if (led_rgb[1] === 1'b0) lit++;
            end
            if (lit == 0) zero_w++;
            if (lit >= 99) full_w++;
        end
        n_chk++; if (zero_w != 5 || full_w != 5) begin
            n_fail++; $display("FAIL blink_windows dark=%0d lit=%0d exp=5/5", zero_w, full_w);
        end
    endtask

    task automatic test_breathe();
        do_write(1, 2, 255);
        do_write(1, 3, 3);
        for (int i = 0; i < 7300; i++) begin
            step();
            n_chk++; if (led_rgb !== m_led) begin n_fail++; $display("FAIL breathe_led n=%0d got=%h exp=%h", m_n, led_rgb, m_led); end
        end
    endtask

    task automatic test_bad_channel();
        int bad, lit;
        bad = 0; lit = 0;
        for (int r = 0; r < 2; r++) begin
            wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_reg3 = (r == 0) ? 2'd3 : 2'd0; wr_data3 = (r == 0) ? 8'd1 : 8'd255;
            step();
            wr_en3 = 1'b0;
            n_chk++; if (wr_ack3 !== 1'b1) begin n_fail++; $display("FAIL badch_ack_pulse got=%b exp=1", wr_ack3); end
            step();
            n_chk++; if (wr_ack3 !== 1'b0) begin n_fail++; $display("FAIL badch_ack_end got=%b exp=0", wr_ack3); end
        end
        for (int i = 0; i < 600; i++) begin
            step();
            if (led_rgb3 !== 9'h1FF) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL badch_no_effect lit_cycles got=%0d exp=0", bad); end
        wr_en3 = 1'b1; wr_ch3 = 2'd2; wr_reg3 = 2'd0; wr_data3 = 8'd255;
        step();
        wr_reg3 = 2'd3; wr_data3 = 8'd1;
        step();
        wr_en3 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (led_rgb3[6] === 1'b0) lit++;
        end
        n_chk++; if (lit < 255) begin n_fail++; $display("FAIL goodch_effect lit_cycles got=%0d exp>=255", lit); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_reg  = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            step();
            n_chk++; if (led_rgb !== m_led) begin n_fail++; $display("FAIL rand_led n=%0d got=%h exp=%h", m_n, led_rgb, m_led); end
            n_chk++; if (tick !== m_tick) begin n_fail++; $display("FAIL rand_tick n=%0d got=%b exp=%b", m_n, tick, m_tick); end
            n_chk++; if (wr_ack !== m_ack) begin n_fail++; $display("FAIL rand_ack n=%0d got=%b exp=%b", m_n, wr_ack, m_ack); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int first_tick;
        first_tick = -1;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 3; k++)
                do_write(c, k, 255);
        for (int c = 0; c < NCH; c++) do_write(c, 3, 1);
        for (int i = 0; i < 300; i++) step();
        for (int i = 0; i < PER && ((m_n - 1) % PER) != 100; i++) step();
        n_chk++; if (led_rgb !== 12'h000) begin n_fail++; $display("FAIL all_lit got=%h exp=000", led_rgb); end
        #2;
        wr_en = 1'b1; wr_ch = 2'd1; wr_reg = 2'd0; wr_data = 8'h10;
        rst_n = 1'b0;
        #1;
        n_chk++; if (led_rgb !== 12'hFFF) begin n_fail++; $display("FAIL async_reset_led got=%h exp=fff", led_rgb); end
        n_chk++; if (tick !== 1'b0) begin n_fail++; $display("FAIL async_reset_tick got=%b exp=0", tick); end
        n_chk++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL async_reset_ack got=%b exp=0", wr_ack); end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (led_rgb !== 12'hFFF) begin n_fail++; $display("FAIL held_reset_led got=%h exp=fff", led_rgb); end
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            step();
            n_chk++; if (led_rgb !== m_led) begin n_fail++; $display("FAIL post_reset_led n=%0d got=%h exp=%h", m_n, led_rgb, m_led); end
            n_chk++; if (tick !== m_tick) begin n_fail++; $display("FAIL post_reset_tick n=%0d got=%b exp=%b", m_n, tick, m_tick); end
            if (tick === 1'b1 && first_tick < 0) first_tick = i;
        end
        n_chk++; if (first_tick != 100) begin n_fail++; $display("FAIL post_reset_first_tick got=%0d exp=100", first_tick); end
    endtask

    initial begin
        test_reset();
        test_static();
        test_blink();
        test_breathe();
        test_bad_channel();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
